ctrl_pipe_ckpt: RTL and testbench

Parametrised control-word pipeline for the intermittent-computing CU. It carries a W-bit control word through STAGES register stages (FET/EXE, EXE/MEM, ...) with stall, per-stage flush/bubble insertion, a dirty tracker, and a serial backup/restore handshake so a non-volatile store can checkpoint and reload every stage across power loss. It sits between the decode LUT and the per-stage control-word muxes, replacing the fixed-width stage registers.

---
 rtl/ctrl_pipe_ckpt.sv | 139 +++++++++++++
 tb/tb_ctrl_pipe_ckpt.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe_ckpt.sv
// Control-word pipeline with stall/flush, a dirty tracker and a serial checkpoint port.
// A non-volatile store backs up or restores every stage one word at a time through the FSM.
module ctrl_pipe_ckpt #(
  parameter int          W        = 32,
  parameter int          STAGES   = 3,
  parameter logic [W-1:0] RST_WORD = {W{1'b0}},
  parameter logic [W-1:0] NOP_WORD = {W{1'b0}}
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Pwr_off,
  input  logic [W-1:0]          Word_in,
  input  logic                  Stall,
  input  logic [STAGES-1:0]     Flush,
  output logic [STAGES*W-1:0]   Stage_out,
  output logic                  Busy,
  output logic                  Dirty_val,
  input  logic                  Rst_DrtyCtrl,
  input  logic                  Backup_en,
  output logic [W-1:0]          Backup_Vout,
  output logic                  Backup_valid,
  input  logic                  Backup_ack,
  output logic                  Backup_done,
  input  logic                  Restore_en,
  input  logic [W-1:0]          Restore_Vin,
  input  logic                  Restore_valid,
  output logic                  Restore_done
);

  localparam int IW = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [IW-1:0] LAST = IW'(STAGES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BACKUP  = 3'd1,
    BK_DONE = 3'd2,
    RESTORE = 3'd3,
    RS_DONE = 3'd4
  } state_t;

  state_t         state;
  logic [IW-1:0]  idx;
  logic [W-1:0]   stg     [STAGES];
  logic [W-1:0]   shifted [STAGES];
  logic [W-1:0]   sel_word;

  always_comb begin
    shifted[0] = Word_in;
    for (int i = 1; i < STAGES; i++) begin
      shifted[i] = stg[i-1];
    end
  end

  // Index decoded by compare so that STAGES=1 needs no special-cased array access.
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < STAGES; i++) begin
      if (idx == IW'(i)) sel_word = stg[i];
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < STAGES; i++) stg[i] <= RST_WORD;
      state     <= IDLE;
      idx       <= '0;
      Dirty_val <= 1'b0;
    end else if (Pwr_off) begin
      for (int i = 0; i < STAGES; i++) stg[i] <= '0;
      state     <= IDLE;
      idx       <= '0;
      Dirty_val <= 1'b0;
    end else begin
      if (Rst_DrtyCtrl) Dirty_val <= 1'b0;
      case (state)
        IDLE: begin
          if (Backup_en) begin
            state <= BACKUP;
            idx   <= '0;
          end else if (Restore_en) begin
            state <= RESTORE;
            idx   <= '0;
          end else begin
            for (int i = 0; i < STAGES; i++) begin
              if (Flush[i])    stg[i] <= NOP_WORD;
              else if (!Stall) stg[i] <= shifted[i];
            end
            if (!Stall || (|Flush)) Dirty_val <= 1'b1;
          end
        end
        BACKUP: begin
          if (Backup_ack) begin
            if (idx == LAST) begin
              idx   <= '0;
              state <= BK_DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        RESTORE: begin
          if (Restore_valid) begin
            for (int i = 0; i < STAGES; i++) begin
              if (idx == IW'(i)) stg[i] <= Restore_Vin;
            end
            if (idx == LAST) begin
              idx   <= '0;
              state <= RS_DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        BK_DONE: begin
          Dirty_val <= 1'b0;
          state     <= IDLE;
        end
        RS_DONE: begin
          Dirty_val <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      Stage_out[i*W +: W] = stg[i];
    end
  end

  assign Busy         = (state != IDLE);
  assign Backup_valid = (state == BACKUP);
  assign Backup_Vout  = (state == BACKUP) ? sel_word : '0;
  assign Backup_done  = (state == BK_DONE);
  assign Restore_done = (state == RS_DONE);

endmodule

// File: tb/tb_ctrl_pipe_ckpt.sv
// Directed vector bench for ctrl_pipe_ckpt: a W=8/STAGES=3 instance driven from a table,
// plus a short hand sequence on a STAGES=1 instance.
module tb_ctrl_pipe_ckpt;

  logic        Clk = 1'b0;
  logic        Rst, Pwr_off, Stall, Rst_DrtyCtrl;
  logic [7:0]  Word_in, Restore_Vin;
  logic [2:0]  Flush;
  logic        Backup_en, Backup_ack, Restore_en, Restore_valid;

  logic [23:0] so3;
  logic        busy3, dirty3, bv3, bd3, rd3;
  logic [7:0]  bvout3;
  logic [7:0]  so1;
  logic        busy1, dirty1, bv1, bd1, rd1;
  logic [7:0]  bvout1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  ctrl_pipe_ckpt #(.W(8), .STAGES(3)) dut3 (
    .Clk(Clk), .Rst(Rst), .Pwr_off(Pwr_off), .Word_in(Word_in), .Stall(Stall),
    .Flush(Flush), .Stage_out(so3), .Busy(busy3), .Dirty_val(dirty3),
    .Rst_DrtyCtrl(Rst_DrtyCtrl), .Backup_en(Backup_en), .Backup_Vout(bvout3),
    .Backup_valid(bv3), .Backup_ack(Backup_ack), .Backup_done(bd3),
    .Restore_en(Restore_en), .Restore_Vin(Restore_Vin), .Restore_valid(Restore_valid),
    .Restore_done(rd3)
  );

  ctrl_pipe_ckpt #(.W(8), .STAGES(1)) dut1 (
    .Clk(Clk), .Rst(Rst), .Pwr_off(Pwr_off), .Word_in(Word_in), .Stall(Stall),
    .Flush(Flush[0:0]), .Stage_out(so1), .Busy(busy1), .Dirty_val(dirty1),
    .Rst_DrtyCtrl(Rst_DrtyCtrl), .Backup_en(Backup_en), .Backup_Vout(bvout1),
    .Backup_valid(bv1), .Backup_ack(Backup_ack), .Backup_done(bd1),
    .Restore_en(Restore_en), .Restore_Vin(Restore_Vin), .Restore_valid(Restore_valid),
    .Restore_done(rd1)
  );

  typedef struct {
    logic       rst, pwr;
    logic [7:0] word;
    logic       stall;
    logic [2:0] flush;
    logic       bk_en, ack, rs_en;
    logic [7:0] vin;
    logic       vld, rdc;
    logic [23:0] e_so;
    logic       e_busy, e_dirty, e_bv;
    logic [7:0] e_bvout;
    logic       e_bd, e_rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(
    logic rst, logic pwr, logic [7:0] word, logic stall, logic [2:0] flush,
    logic bk_en, logic ack, logic rs_en, logic [7:0] vin, logic vld, logic rdc,
    logic [23:0] e_so, logic e_busy, logic e_dirty, logic e_bv, logic [7:0] e_bvout,
    logic e_bd, logic e_rd);
    vec_t r;
    r.rst = rst; r.pwr = pwr; r.word = word; r.stall = stall; r.flush = flush;
    r.bk_en = bk_en; r.ack = ack; r.rs_en = rs_en; r.vin = vin; r.vld = vld; r.rdc = rdc;
    r.e_so = e_so; r.e_busy = e_busy; r.e_dirty = e_dirty; r.e_bv = e_bv;
    r.e_bvout = e_bvout; r.e_bd = e_bd; r.e_rd = e_rd;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t r);
    Rst = r.rst; Pwr_off = r.pwr; Word_in = r.word; Stall = r.stall; Flush = r.flush;
    Backup_en = r.bk_en; Backup_ack = r.ack; Restore_en = r.rs_en;
    Restore_Vin = r.vin; Restore_valid = r.vld; Rst_DrtyCtrl = r.rdc;
  endtask

  initial begin
    // rst pwr word stall flush bk ack rs vin vld rdc | so busy dirty bv bvout bd rd
    vecs.push_back(v(1,0,8'h00,0,3'b000,0,0,0,8'h00,0,0, 24'h000000,0,0,0,8'h00,0,0)); // 0 reset
    vecs.push_back(v(0,0,8'h11,0,3'b000,0,0,0,8'h00,0,0, 24'h000011,0,1,0,8'h00,0,0));
    vecs.push_back(v(0,0,8'h22,0,3'b000,0,0,0,8'h00,0,0, 24'h001122,0,1,0,8'h00,0,0));
    vecs.push_back(v(0,0,8'h33,0,3'b000,0,0,0,8'h00,0,0, 24'h112233,0,1,0,8'h00,0,0));
    vecs.push_back(v(0,0,8'h77,1,3'b010,0,0,0,8'h00,0,0, 24'h110033,0,1,0,8'h00,0,0)); // 4 stall+flush
    vecs.push_back(v(0,0,8'h77,1,3'b000,0,0,0,8'h00,0,1, 24'h110033,0,0,0,8'h00,0,0)); // 5 dirty clear
    vecs.push_back(v(0,0,8'h44,0,3'b000,0,0,0,8'h00,0,1, 24'h003344,0,1,0,8'h00,0,0)); // 6 load beats clear
    vecs.push_back(v(0,0,8'h11,0,3'b000,0,0,0,8'h00,0,0, 24'h334411,0,1,0,8'h00,0,0));
    vecs.push_back(v(0,0,8'h22,0,3'b000,0,0,0,8'h00,0,0, 24'h441122,0,1,0,8'h00,0,0));
    vecs.push_back(v(0,0,8'h33,0,3'b000,0,0,0,8'h00,0,0, 24'h112233,0,1,0,8'h00,0,0));
    vecs.push_back(v(0,0,8'h55,0,3'b000,1,0,0,8'h00,0,0, 24'h112233,1,1,1,8'h33,0,0)); // 10 enter backup
    vecs.push_back(v(0,0,8'h66,0,3'b111,0,0,1,8'h00,0,0, 24'h112233,1,1,1,8'h33,0,0));
    vecs.push_back(v(0,0,8'h66,0,3'b111,0,0,0,8'h00,0,0, 24'h112233,1,1,1,8'h33,0,0));
    vecs.push_back(v(0,0,8'h66,0,3'b000,0,0,0,8'h00,0,0, 24'h112233,1,1,1,8'h33,0,0));
    vecs.push_back(v(0,0,8'h66,0,3'b000,0,0,0,8'h00,0,0, 24'h112233,1,1,1,8'h33,0,0));
    vecs.push_back(v(0,0,8'h00,0,3'b000,0,1,0,8'h00,0,0, 24'h112233,1,1,1,8'h22,0,0)); // 15 acks
    vecs.push_back(v(0,0,8'h00,0,3'b000,0,1,0,8'h00,0,0, 24'h112233,1,1,1,8'h11,0,0));
    vecs.push_back(v(0,0,8'h00,0,3'b000,0,1,0,8'h00,0,0, 24'h112233,1,1,0,8'h00,1,0)); // 17 BK_DONE
    vecs.push_back(v(0,0,8'h00,1,3'b000,0,0,0,8'h00,0,0, 24'h112233,0,0,0,8'h00,0,0));
    vecs.push_back(v(0,0,8'h00,1,3'b000,1,0,0,8'h00,0,0, 24'h112233,1,0,1,8'h33,0,0)); // 19 backup again
    vecs.push_back(v(0,0,8'h00,1,3'b000,0,1,0,8'h00,0,0, 24'h112233,1,0,1,8'h22,0,0));
    vecs.push_back(v(0,1,8'h00,1,3'b000,0,1,0,8'h00,0,0, 24'h000000,0,0,0,8'h00,0,0)); // 21 power loss
    vecs.push_back(v(0,0,8'h00,1,3'b000,0,1,0,8'h00,0,0, 24'h000000,0,0,0,8'h00,0,0));
    vecs.push_back(v(0,0,8'h00,1,3'b000,0,0,1,8'h00,0,0, 24'h000000,1,0,0,8'h00,0,0)); // 23 restore
    vecs.push_back(v(0,0,8'h00,1,3'b000,0,0,0,8'h33,1,0, 24'h000033,1,0,0,8'h00,0,0));
    vecs.push_back(v(0,0,8'h00,1,3'b000,0,0,0,8'h99,0,0, 24'h000033,1,0,0,8'h00,0,0));
    vecs.push_back(v(0,0,8'h00,1,3'b000,0,0,0,8'h22,1,0, 24'h002233,1,0,0,8'h00,0,0));
    vecs.push_back(v(0,0,8'h00,1,3'b000,0,0,0,8'h88,0,0, 24'h002233,1,0,0,8'h00,0,0));
    vecs.push_back(v(0,0,8'h00,1,3'b000,0,0,0,8'h11,1,0, 24'h112233,1,0,0,8'h00,0,1)); // 28 RS_DONE
    vecs.push_back(v(0,0,8'h00,1,3'b000,0,0,0,8'h00,0,0, 24'h112233,0,0,0,8'h00,0,0));
    vecs.push_back(v(0,0,8'h00,1,3'b000,1,0,1,8'h00,0,0, 24'h112233,1,0,1,8'h33,0,0)); // 30 both enables
    vecs.push_back(v(0,0,8'h00,1,3'b000,0,0,1,8'hAA,1,0, 24'h112233,1,0,1,8'h33,0,0));
    vecs.push_back(v(0,0,8'h00,1,3'b000,0,1,0,8'h00,0,0, 24'h112233,1,0,1,8'h22,0,0));
    vecs.push_back(v(0,0,8'h00,1,3'b000,0,1,0,8'h00,0,0, 24'h112233,1,0,1,8'h11,0,0));
    vecs.push_back(v(0,0,8'h00,1,3'b000,0,1,0,8'h00,0,0, 24'h112233,1,0,0,8'h00,1,0));
    vecs.push_back(v(0,0,8'h00,1,3'b000,0,0,0,8'h00,0,0, 24'h112233,0,0,0,8'h00,0,0));
    vecs.push_back(v(0,0,8'h00,1,3'b000,0,0,1,8'h00,0,0, 24'h112233,1,0,0,8'h00,0,0)); // 36 restore
    vecs.push_back(v(0,0,8'h00,1,3'b000,0,0,0,8'h01,1,0, 24'h112201,1,0,0,8'h00,0,0));
    vecs.push_back(v(0,0,8'h00,1,3'b000,0,0,0,8'h02,1,0, 24'h110201,1,0,0,8'h00,0,0));
    vecs.push_back(v(1,0,8'h00,1,3'b000,0,0,0,8'h03,1,0, 24'h000000,0,0,0,8'h00,0,0)); // 39 reset aborts
    vecs.push_back(v(0,0,8'h00,1,3'b000,0,0,0,8'h03,1,0, 24'h000000,0,0,0,8'h00,0,0));

    drive(vecs[0]);
    @(negedge Clk);
    foreach (vecs[k]) begin
      drive(vecs[k]);
      @(posedge Clk);
      #1;
      chk($sformatf("v%0d stage_out", k), 32'(so3),    32'(vecs[k].e_so));
      chk($sformatf("v%0d busy", k),      32'(busy3),  32'(vecs[k].e_busy));
      chk($sformatf("v%0d dirty", k),     32'(dirty3), 32'(vecs[k].e_dirty));
      chk($sformatf("v%0d bk_valid", k),  32'(bv3),    32'(vecs[k].e_bv));
      chk($sformatf("v%0d bk_vout", k),   32'(bvout3), 32'(vecs[k].e_bvout));
      chk($sformatf("v%0d bk_done", k),   32'(bd3),    32'(vecs[k].e_bd));
      chk($sformatf("v%0d rs_done", k),   32'(rd3),    32'(vecs[k].e_rd));
      @(negedge Clk);
    end

    // Single-stage instance: one ack completes the backup.
    drive(v(1,0,8'h00,0,3'b000,0,0,0,8'h00,0,0, 24'h0,0,0,0,8'h00,0,0));
    @(posedge Clk); #1;
    chk("s1 reset stage", 32'(so1), 32'h00);
    chk("s1 reset busy", 32'(busy1), 32'h0);
    @(negedge Clk);
    drive(v(0,0,8'h5A,0,3'b000,0,0,0,8'h00,0,0, 24'h0,0,0,0,8'h00,0,0));
    @(posedge Clk); #1;
    chk("s1 load stage", 32'(so1), 32'h5A);
    chk("s1 load dirty", 32'(dirty1), 32'h1);
    @(negedge Clk);
    drive(v(0,0,8'hC3,0,3'b000,1,0,0,8'h00,0,0, 24'h0,0,0,0,8'h00,0,0));
    @(posedge Clk); #1;
    chk("s1 bk vout", 32'(bvout1), 32'h5A);
    chk("s1 bk valid", 32'(bv1), 32'h1);
    chk("s1 bk hold stage", 32'(so1), 32'h5A);
    @(negedge Clk);
    drive(v(0,0,8'h00,0,3'b000,0,1,0,8'h00,0,0, 24'h0,0,0,0,8'h00,0,0));
    @(posedge Clk); #1;
    chk("s1 bk done", 32'(bd1), 32'h1);
    chk("s1 bk valid off", 32'(bv1), 32'h0);
    @(negedge Clk);
    drive(v(0,0,8'h00,1,3'b000,0,0,0,8'h00,0,0, 24'h0,0,0,0,8'h00,0,0));
    @(posedge Clk); #1;
    chk("s1 done pulse end", 32'(bd1), 32'h0);
    chk("s1 idle busy", 32'(busy1), 32'h0);
    chk("s1 dirty cleared", 32'(dirty1), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
